// File: rtl/friscv_mem_loader_pkg.sv
// friscv_sv_pkg: loader command bytes, FSM state and write-target types shared by the memory loader.
package friscv_sv_pkg;
  localparam logic [7:0] LD_CMD_LOAD_IMEM = 8'h01;
  localparam logic [7:0] LD_CMD_LOAD_DMEM = 8'h02;
  localparam logic [7:0] LD_CMD_RUN       = 8'h03;
  localparam logic [7:0] LD_CMD_HALT      = 8'h04;
  typedef enum logic [1:0] {LD_IDLE, LD_HDR, LD_DATA, LD_RUN} loader_state_t;
  typedef enum logic {TGT_IMEM, TGT_DMEM} ld_target_t;
endpackage

// File: rtl/friscv_byte_packer.sv
// friscv_byte_packer: packs a byte stream LSB-first into ARCH-bit words.
//  clk, rst_n     clock, async active-low reset
//  valid_i/data_i accepted byte
//  idx_o          byte position the next accepted byte will occupy (0..3)
//  word_o         last completed word, held until the next one completes
//  word_valid_o   one-cycle pulse in the cycle after the 4th byte of a word
module friscv_byte_packer #(
  parameter int ARCH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [7:0]      data_i,
  output logic [1:0]      idx_o,
  output logic [ARCH-1:0] word_o,
  output logic            word_valid_o
);
  logic [1:0]      idx_q;
  logic [ARCH-9:0] buf_q;
  logic [ARCH-1:0] word_q;
  logic            vld_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      buf_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= valid_i && idx_q == 2'd3;
      if (valid_i) begin
        idx_q <= idx_q + 2'd1;
        buf_q <= {data_i, buf_q[ARCH-9:8]};
        if (idx_q == 2'd3) word_q <= {data_i, buf_q};
      end
    end
  end
  assign idx_o        = idx_q;
  assign word_o       = word_q;
  assign word_valid_o = vld_q;
endmodule

// File: rtl/friscv_mem_loader.sv
// friscv_mem_loader: byte-stream frame loader writing imem/dmem words and gating the core reset.
//  ld_valid_in/ld_ready_out/ld_data_in  byte channel (never back-pressures once out of reset)
//  mem_addr_out/mem_wdata_out           byte address and word of the current write
//  imem_we_out/dmem_we_out              one-cycle write strobes
//  core_rst_n_out                       core reset, released only in RUN
//  busy_out/err_out/words_loaded_out    frame in progress, sticky bad command, words written
module friscv_mem_loader
  import friscv_sv_pkg::*;
#(
  parameter int ARCH             = 32,
  parameter int IMEM_DEPTH_WORDS = 1024,
  parameter int DMEM_DEPTH_WORDS = 1024,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid_in,
  output logic                 ld_ready_out,
  input  logic [7:0]           ld_data_in,
  output logic [CNT_WIDTH+1:0] mem_addr_out,
  output logic [ARCH-1:0]      mem_wdata_out,
  output logic                 imem_we_out,
  output logic                 dmem_we_out,
  output logic                 core_rst_n_out,
  output logic                 busy_out,
  output logic                 err_out,
  output logic [CNT_WIDTH-1:0] words_loaded_out
);
  localparam logic [CNT_WIDTH-1:0] IMASK = CNT_WIDTH'(IMEM_DEPTH_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] DMASK = CNT_WIDTH'(DMEM_DEPTH_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  loader_state_t        state_q;
  ld_target_t           tgt_q;
  logic                 ready_q, err_q, core_rst_n_q;
  logic [23:0]          hdr_q;
  logic [1:0]           hcnt_q;
  logic [CNT_WIDTH-1:0] addr_q, rem_q, words_q;
  logic                 acc, pk_vld;
  logic [1:0]           pk_idx;
  logic [CNT_WIDTH-1:0] mask, hdr_addr, hdr_cnt;
  assign acc      = ld_valid_in && ready_q;
  assign mask     = tgt_q == TGT_IMEM ? IMASK : DMASK;
  // hdr_q holds {cnt_lo, addr_hi, addr_lo} once three header bytes are in; the live byte is cnt_hi
  assign hdr_addr = CNT_WIDTH'(hdr_q[15:0]);
  assign hdr_cnt  = CNT_WIDTH'({ld_data_in, hdr_q[23:16]});
  friscv_byte_packer #(.ARCH(ARCH)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (acc && state_q == LD_DATA),
    .data_i      (ld_data_in),
    .idx_o       (pk_idx),
    .word_o      (mem_wdata_out),
    .word_valid_o(pk_vld)
  );
  // The frame ends on the last data byte, so the final strobe lands in IDLE and a following
  // command byte may share that cycle; a LOAD there still wins over the counter updates below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LD_IDLE;
      tgt_q        <= TGT_IMEM;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      hdr_q        <= '0;
      hcnt_q       <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      words_q      <= '0;
    end else begin
      ready_q <= 1'b1;
      if (pk_vld) begin
        addr_q  <= (addr_q + ONE) & mask;
        words_q <= words_q + ONE;
      end
      case (state_q)
        LD_IDLE: if (acc) begin
          if (ld_data_in == LD_CMD_LOAD_IMEM || ld_data_in == LD_CMD_LOAD_DMEM) begin
            state_q <= LD_HDR;
            tgt_q   <= ld_data_in == LD_CMD_LOAD_IMEM ? TGT_IMEM : TGT_DMEM;
            err_q   <= 1'b0;
            words_q <= '0;
            hcnt_q  <= '0;
          end else if (ld_data_in == LD_CMD_RUN) begin
            state_q      <= LD_RUN;
            core_rst_n_q <= 1'b1;
            err_q        <= 1'b0;
          end else begin
            err_q <= ld_data_in != LD_CMD_HALT;
          end
        end
        LD_HDR: if (acc) begin
          hdr_q  <= {ld_data_in, hdr_q[23:8]};
          hcnt_q <= hcnt_q + 2'd1;
          if (hcnt_q == 2'd3) begin
            addr_q  <= hdr_addr & mask;
            rem_q   <= hdr_cnt;
            state_q <= hdr_cnt == '0 ? LD_IDLE : LD_DATA;
          end
        end
        LD_DATA: if (acc && pk_idx == 2'd3) begin
          rem_q <= rem_q - ONE;
          if (rem_q == ONE) state_q <= LD_IDLE;
        end
        LD_RUN: if (acc && ld_data_in == LD_CMD_HALT) begin
          state_q      <= LD_IDLE;
          core_rst_n_q <= 1'b0;
        end
        default: state_q <= LD_IDLE;
      endcase
    end
  end
  assign ld_ready_out     = ready_q;
  assign mem_addr_out     = {addr_q, 2'b00};
  assign imem_we_out      = pk_vld && tgt_q == TGT_IMEM;
  assign dmem_we_out      = pk_vld && tgt_q == TGT_DMEM;
  assign core_rst_n_out   = core_rst_n_q;
  assign busy_out         = state_q == LD_HDR || state_q == LD_DATA;
  assign err_out          = err_q;
  assign words_loaded_out = words_q;
endmodule

// File: tb/tb_friscv_mem_loader.sv
// tb_friscv_mem_loader: directed frames with a write scoreboard drained by a strobe monitor.
module tb_friscv_mem_loader;
  logic        clk = 1'b0, rst_n = 1'b0, ld_valid_in = 1'b0;
  logic [7:0]  ld_data_in = '0;
  logic        ld_ready_out, imem_we_out, dmem_we_out, core_rst_n_out, busy_out, err_out;
  logic [17:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [15:0] words_loaded_out;
  logic [51:0] exp_q[$];
  logic [51:0] mon_got, mon_exp;
  logic [7:0]  seq[$];
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  friscv_mem_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ld_valid_in     (ld_valid_in),
    .ld_ready_out    (ld_ready_out),
    .ld_data_in      (ld_data_in),
    .mem_addr_out    (mem_addr_out),
    .mem_wdata_out   (mem_wdata_out),
    .imem_we_out     (imem_we_out),
    .dmem_we_out     (dmem_we_out),
    .core_rst_n_out  (core_rst_n_out),
    .busy_out        (busy_out),
    .err_out         (err_out),
    .words_loaded_out(words_loaded_out)
  );
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic send(input logic [7:0] b);
    ld_valid_in = 1'b1;
    ld_data_in  = b;
    @(negedge clk);
    ld_valid_in = 1'b0;
  endtask
  task automatic send_seq(input int gap);
    foreach (seq[i]) begin
      send(seq[i]);
      if (gap != 0) repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic exp_wr(input bit d, input logic [17:0] a, input logic [31:0] w);
    exp_q.push_back({~d, d, a, w});
  endtask
  always @(negedge clk) begin
    if (rst_n && (imem_we_out || dmem_we_out)) begin
      mon_got = {imem_we_out, dmem_we_out, mem_addr_out, mem_wdata_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %0h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL write got %0h expected %0h", mon_got, mon_exp);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
  initial begin
    idle(2);
    chk("rst_ready", ld_ready_out, 0);
    chk("rst_core", core_rst_n_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_words", words_loaded_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_wdata", mem_wdata_out, 0);
    rst_n = 1'b1;
    idle(2);
    chk("ready", ld_ready_out, 1);
    chk("core_held", core_rst_n_out, 0);
    exp_wr(0, 18'h0, 32'h44332211);
    exp_wr(0, 18'h4, 32'h88776655);
    seq = {8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_seq(0);
    idle(3);
    chk("imem_words", words_loaded_out, 2);
    chk("imem_busy", busy_out, 0);
    chk("imem_drain", exp_q.size(), 0);
    exp_wr(1, 18'hFFC, 32'hDDCCBBAA);
    exp_wr(1, 18'h000, 32'h04030201);
    seq = {8'h02};
    send_seq(0);
    chk("hdr_busy", busy_out, 1);
    seq = {8'hFF, 8'h03, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    send_seq(0);
    idle(3);
    chk("dmem_words", words_loaded_out, 2);
    chk("dmem_drain", exp_q.size(), 0);
    seq = {8'h55};
    send_seq(0);
    chk("bad_err", err_out, 1);
    chk("bad_core", core_rst_n_out, 0);
    chk("bad_busy", busy_out, 0);
    seq = {8'h01};
    send_seq(0);
    chk("err_clear", err_out, 0);
    chk("load_busy", busy_out, 1);
    seq = {8'h00, 8'h00, 8'h00, 8'h00};
    send_seq(0);
    chk("cnt0_busy", busy_out, 0);
    chk("cnt0_words", words_loaded_out, 0);
    idle(3);
    seq = {8'h03};
    send_seq(0);
    chk("run_core", core_rst_n_out, 1);
    chk("run_busy", busy_out, 0);
    seq = {8'h01, 8'h55, 8'h02};
    send_seq(0);
    chk("run_ignore_busy", busy_out, 0);
    chk("run_ignore_err", err_out, 0);
    chk("run_ignore_core", core_rst_n_out, 1);
    seq = {8'h04};
    send_seq(0);
    chk("halt_core", core_rst_n_out, 0);
    seq = {8'h01};
    send_seq(0);
    chk("halt_idle_load", busy_out, 1);
    seq = {8'h10, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
    send_seq(0);
    #2 rst_n = 1'b0;
    idle(1);
    chk("mid_rst_busy", busy_out, 0);
    chk("mid_rst_wdata", mem_wdata_out, 0);
    chk("mid_rst_ready", ld_ready_out, 0);
    rst_n = 1'b1;
    idle(3);
    chk("mid_rst_drain", exp_q.size(), 0);
    exp_wr(0, 18'h40, 32'hEFBEADDE);
    seq = {8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_seq(0);
    idle(3);
    chk("after_rst_words", words_loaded_out, 1);
    chk("after_rst_drain", exp_q.size(), 0);
    exp_wr(0, 18'h0, 32'h44332211);
    exp_wr(0, 18'h4, 32'h88776655);
    seq = {8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_seq(3);
    idle(3);
    chk("gap_words", words_loaded_out, 2);
    chk("gap_busy", busy_out, 0);
    chk("gap_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
